// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO that drains one word per cycle into a
// single-port data memory, with lw forwarding from the youngest buffered store.
module store_buffer #(
   parameter int DEPTH     = 4,
   parameter int MEM_WORDS = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     MemWrite,
   input  logic [31:0]              ALU_result,
   input  logic [31:0]              Write_data,
   output logic                     store_ready,
   output logic                     align_err,
   input  logic                     MemRead,
   input  logic [31:0]              load_addr,
   output logic                     load_valid,
   output logic [31:0]              load_data,
   output logic [$clog2(DEPTH):0]   buf_count,
   output logic                     buf_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(MEM_WORDS);
   localparam int CW = AW + 1;

   logic [IW-1:0] r_idx  [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [31:0]   r_mem  [MEM_WORDS];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          r_load_valid;
   logic [31:0]   r_load_data;
   logic          r_align_err;

   logic [IW-1:0] w_st_idx;
   logic [IW-1:0] w_ld_idx;
   logic          w_aligned;
   logic          w_push;
   logic          w_drain;
   logic          w_hit;
   logic [31:0]   w_fwd;
   logic          w_unused;

   assign w_st_idx  = ALU_result[2 +: IW];
   assign w_ld_idx  = load_addr[2 +: IW];
   assign w_unused  = ^{ALU_result, load_addr};
   assign w_aligned = (ALU_result[1:0] == 2'b00);

   assign store_ready = (r_count < CW'(DEPTH));
   assign w_push      = reset && MemWrite && store_ready && w_aligned;
   // A load miss owns the memory port this cycle, so the drain waits.
   assign w_drain     = reset && (r_count != {CW{1'b0}}) && !(MemRead && !w_hit);

   assign buf_count  = r_count;
   assign buf_empty  = (r_count == {CW{1'b0}});
   assign load_valid = r_load_valid;
   assign load_data  = r_load_data;
   assign align_err  = r_align_err;

   // Walk entries oldest to youngest so the last match seen is the youngest.
   always_comb begin
      w_hit = 1'b0;
      w_fwd = 32'h0000_0000;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < r_count) && (r_idx[r_rd_ptr + AW'(k)] == w_ld_idx)) begin
            w_hit = 1'b1;
            w_fwd = r_data[r_rd_ptr + AW'(k)];
         end else begin
            w_hit = w_hit;
            w_fwd = w_fwd;
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_ptr <= {AW{1'b0}};
         r_wr_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_drain) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_drain})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO entry storage
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_idx[r_wr_ptr]  <= w_st_idx;
         r_data[r_wr_ptr] <= Write_data;
      end
   end

   // Data memory write port, fed only by the drain
   always_ff @(posedge clk) begin
      if (w_drain) begin
         r_mem[r_idx[r_rd_ptr]] <= r_data[r_rd_ptr];
      end
   end

   // Load result and misalignment pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_load_valid <= 1'b0;
         r_load_data  <= 32'h0000_0000;
         r_align_err  <= 1'b0;
      end else begin
         r_align_err <= MemWrite && !w_aligned;
         if (MemRead) begin
            r_load_valid <= 1'b1;
            r_load_data  <= w_hit ? w_fwd : r_mem[w_ld_idx];
         end else begin
            r_load_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven directed vectors plus hand-written reset,
// stall and wrap sequences for store_buffer (DEPTH=4, MEM_WORDS=256).
module tb_store_buffer;
   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALU_result;
   logic [31:0] Write_data;
   logic        store_ready;
   logic        align_err;
   logic        MemRead;
   logic [31:0] load_addr;
   logic        load_valid;
   logic [31:0] load_data;
   logic [2:0]  buf_count;
   logic        buf_empty;

   int checks = 0;
   int errors = 0;

   store_buffer #(.DEPTH(4), .MEM_WORDS(256)) dut (
      .clk(clk), .reset(reset),
      .MemWrite(MemWrite), .ALU_result(ALU_result), .Write_data(Write_data),
      .store_ready(store_ready), .align_err(align_err),
      .MemRead(MemRead), .load_addr(load_addr),
      .load_valid(load_valid), .load_data(load_data),
      .buf_count(buf_count), .buf_empty(buf_empty)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic        re;
      logic [31:0] ra;
      logic        e_rdy;
      logic [2:0]  e_cnt;
      logic        e_lv;
      logic [31:0] e_ld;
      logic        c_ld;
      logic        e_ae;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic re, input logic [31:0] ra);
      MemWrite   = we;
      ALU_result = wa;
      Write_data = wd;
      MemRead    = re;
      load_addr  = ra;
   endtask

   task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra);
      drive(we, wa, wd, re, ra);
      @(posedge clk);
      #1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic load_chk(input string name, input logic [31:0] ra, input logic [31:0] exp);
      step(1'b0, 32'h0, 32'h0, 1'b1, ra);
      chk({name, " valid"}, {31'h0, load_valid}, 32'h1);
      chk({name, " data"}, load_data, exp);
   endtask

   initial begin
      //            we    wa          wd            re    ra          rdy   cnt   lv    ld            cld   ae
      vecs.push_back({1'b1, 32'h4,    32'h12345678, 1'b0, 32'h0,    1'b1, 3'd1, 1'b0, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b0, 32'h0,    1'b1, 3'd0, 1'b0, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b1, 32'h4,    1'b1, 3'd0, 1'b1, 32'h12345678, 1'b1, 1'b0});
      vecs.push_back({1'b1, 32'h8,    32'hCAFEF00D, 1'b0, 32'h0,    1'b1, 3'd1, 1'b0, 32'h12345678, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b0, 32'h0,    1'b1, 3'd0, 1'b0, 32'h12345678, 1'b1, 1'b0});
      vecs.push_back({1'b1, 32'h3C,   32'hABCDEF01, 1'b1, 32'h100,  1'b1, 3'd1, 1'b1, 32'h00000000, 1'b0, 1'b0});
      vecs.push_back({1'b1, 32'h3C,   32'h11111111, 1'b1, 32'h100,  1'b1, 3'd2, 1'b1, 32'h00000000, 1'b0, 1'b0});
      vecs.push_back({1'b1, 32'h10,   32'h22222222, 1'b1, 32'h100,  1'b1, 3'd3, 1'b1, 32'h00000000, 1'b0, 1'b0});
      vecs.push_back({1'b1, 32'h14,   32'h33333333, 1'b1, 32'h100,  1'b1, 3'd4, 1'b1, 32'h00000000, 1'b0, 1'b0});
      vecs.push_back({1'b1, 32'h8,    32'hDEADBEEF, 1'b1, 32'h100,  1'b0, 3'd4, 1'b1, 32'h00000000, 1'b0, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b1, 32'h3C,   1'b0, 3'd3, 1'b1, 32'h11111111, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b0, 32'h0,    1'b1, 3'd2, 1'b0, 32'h11111111, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b0, 32'h0,    1'b1, 3'd1, 1'b0, 32'h11111111, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b0, 32'h0,    1'b1, 3'd0, 1'b0, 32'h11111111, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b1, 32'h8,    1'b1, 3'd0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b1, 32'h3C,   1'b1, 3'd0, 1'b1, 32'h11111111, 1'b1, 1'b0});
      vecs.push_back({1'b1, 32'h6,    32'h55555555, 1'b0, 32'h0,    1'b1, 3'd0, 1'b0, 32'h11111111, 1'b1, 1'b1});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b0, 32'h0,    1'b1, 3'd0, 1'b0, 32'h11111111, 1'b1, 1'b0});
      vecs.push_back({1'b1, 32'h10,   32'h77777777, 1'b1, 32'h10,   1'b1, 3'd1, 1'b1, 32'h22222222, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b1, 32'h10,   1'b1, 3'd0, 1'b1, 32'h77777777, 1'b1, 1'b0});
      vecs.push_back({1'b1, 32'h404,  32'h0BADF00D, 1'b0, 32'h0,    1'b1, 3'd1, 1'b0, 32'h77777777, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b0, 32'h0,    1'b1, 3'd0, 1'b0, 32'h77777777, 1'b1, 1'b0});
      vecs.push_back({1'b0, 32'h0,    32'h0,        1'b1, 32'h4,    1'b1, 3'd0, 1'b1, 32'h0BADF00D, 1'b1, 1'b0});

      // Reset held for two cycles
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset count", {29'h0, buf_count}, 32'h0);
      chk("reset empty", {31'h0, buf_empty}, 32'h1);
      chk("reset lvalid", {31'h0, load_valid}, 32'h0);
      chk("reset ldata", load_data, 32'h0);
      chk("reset ready", {31'h0, store_ready}, 32'h1);
      chk("reset aerr", {31'h0, align_err}, 32'h0);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
         chk($sformatf("row%0d ready", i), {31'h0, store_ready}, {31'h0, vecs[i].e_rdy});
         @(posedge clk);
         #1;
         chk($sformatf("row%0d count", i), {29'h0, buf_count}, {29'h0, vecs[i].e_cnt});
         chk($sformatf("row%0d empty", i), {31'h0, buf_empty}, {31'h0, (vecs[i].e_cnt == 3'd0)});
         chk($sformatf("row%0d lvalid", i), {31'h0, load_valid}, {31'h0, vecs[i].e_lv});
         chk($sformatf("row%0d aerr", i), {31'h0, align_err}, {31'h0, vecs[i].e_ae});
         if (vecs[i].c_ld) begin
            chk($sformatf("row%0d ldata", i), load_data, vecs[i].e_ld);
         end
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Reset while stores are still buffered: one drains, two are discarded
      step(1'b1, 32'h4,  32'hAAAA0001, 1'b1, 32'h100);
      step(1'b1, 32'h8,  32'hAAAA0002, 1'b1, 32'h100);
      step(1'b1, 32'h3C, 32'hAAAA0003, 1'b1, 32'h100);
      chk("pre-rst count", {29'h0, buf_count}, 32'h3);
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("drain1 count", {29'h0, buf_count}, 32'h2);
      reset = 1'b0;
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      reset = 1'b1;
      chk("midrst count", {29'h0, buf_count}, 32'h0);
      chk("midrst empty", {31'h0, buf_empty}, 32'h1);
      chk("midrst lvalid", {31'h0, load_valid}, 32'h0);
      chk("midrst ldata", load_data, 32'h0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("post-rst count", {29'h0, buf_count}, 32'h0);
      load_chk("drained 0x4", 32'h4, 32'hAAAA0001);
      load_chk("discarded 0x8", 32'h8, 32'hCAFEF00D);
      load_chk("discarded 0x3C", 32'h3C, 32'h11111111);
      load_chk("wrap 0x404", 32'h404, 32'hAAAA0001);
      load_chk("byte-off 0x3F", 32'h3F, 32'h11111111);

      // Misaligned store while full is still flagged and never queued
      step(1'b1, 32'h20, 32'h1, 1'b1, 32'h100);
      step(1'b1, 32'h24, 32'h2, 1'b1, 32'h100);
      step(1'b1, 32'h28, 32'h3, 1'b1, 32'h100);
      step(1'b1, 32'h2C, 32'h4, 1'b1, 32'h100);
      step(1'b1, 32'h31, 32'h5, 1'b1, 32'h100);
      chk("full aerr", {31'h0, align_err}, 32'h1);
      chk("full count", {29'h0, buf_count}, 32'h4);
      chk("full ready", {31'h0, store_ready}, 32'h0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("aerr pulse", {31'h0, align_err}, 32'h0);
      repeat (4) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("final empty", {31'h0, buf_empty}, 32'h1);
      load_chk("drained 0x2C", 32'h2C, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
